pe_config_loader: RTL and testbench

- Programming-phase front end for the PE mesh.
- Accepts a stream of configuration beats from the host/switch over valid/ready. Each beat carries a target PE index, a 4-bit instruction and a 32-bit data word.
- Per beat, drives a one-hot load pulse plus broadcast instruction/data to the PEs, tracks which PEs have been programmed, and raises mesh_run once the session's last beat has been issued.
- Sits directly upstream of every PE's reset/load/instruction/internal_data_in pins.

---
 rtl/pe_config_loader.sv | 160 ++++++++++++++++
 tb/tb_pe_config_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_config_loader.sv
// Programming-phase front end for the PE mesh: turns a valid/ready stream of config
// beats into one-hot load pulses, broadcast instruction/data and a programmed bitmap.
module pe_config_loader #(
  parameter int NUM_PE   = 16,
  parameter int IDX_W    = 6,
  parameter int LOAD_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_bcast,
  input  logic              cfg_clear,
  input  logic [3:0]        cfg_instr,
  input  logic [31:0]       cfg_data,
  input  logic              cfg_last,
  input  logic              reconfig,
  output logic [NUM_PE-1:0] pe_reset,
  output logic [NUM_PE-1:0] pe_load,
  output logic [3:0]        pe_instruction,
  output logic [31:0]       pe_data,
  output logic [NUM_PE-1:0] programmed,
  output logic              mesh_run,
  output logic              err_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_e;

  localparam logic [IDX_W:0] NUM_PE_W = (IDX_W+1)'(NUM_PE);
  localparam logic [3:0]     GAP_LAST = 4'((LOAD_GAP > 0) ? (LOAD_GAP - 1) : 0);

  state_e            state_q, state_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              last_q, last_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [NUM_PE-1:0] pe_reset_q, pe_reset_d;
  logic [NUM_PE-1:0] pe_load_q, pe_load_d;
  logic [3:0]        instr_q, instr_d;
  logic [31:0]       data_q, data_d;
  logic [NUM_PE-1:0] programmed_q, programmed_d;
  logic              mesh_run_q, mesh_run_d;
  logic              err_idx_q, err_idx_d;

  logic              xfer;
  logic              in_range;
  logic [NUM_PE-1:0] onehot;

  assign xfer     = cfg_valid & cfg_ready_q;
  assign in_range = ({1'b0, cfg_idx} < NUM_PE_W);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      onehot[i] = (cfg_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = '0;
    unique case (state_q)
      IDLE:  if (xfer) state_d = ISSUE;
      ISSUE: begin
        if (LOAD_GAP > 0) state_d = GAP;
        else              state_d = last_q ? DONE : IDLE;
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = last_q ? DONE : IDLE;
          gap_cnt_d = '0;
        end
      end
      DONE:  if (reconfig) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The beat is decoded straight off the bus on the transfer edge so the load
  // pulse lands in the ISSUE cycle, one cycle after the handshake.
  always_comb begin
    last_d       = last_q;
    cfg_ready_d  = (state_d == IDLE);
    mesh_run_d   = (state_d == DONE);
    pe_reset_d   = '0;
    pe_load_d    = '0;
    instr_d      = instr_q;
    data_d       = data_q;
    programmed_d = programmed_q;
    err_idx_d    = err_idx_q;
    if (state_q == IDLE && xfer) begin
      last_d = cfg_last;
      if (cfg_clear) begin
        pe_reset_d   = '1;
        programmed_d = '0;
      end else begin
        instr_d = cfg_instr;
        data_d  = cfg_data;
        if (cfg_bcast) begin
          pe_load_d    = '1;
          programmed_d = '1;
        end else if (in_range) begin
          pe_load_d    = onehot;
          programmed_d = programmed_q | onehot;
        end else begin
          err_idx_d = 1'b1;
        end
      end
    end
    if (state_q == DONE && reconfig) begin
      programmed_d = '0;
      err_idx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready_q  <= 1'b0;
      pe_reset_q   <= '1;
      pe_load_q    <= '0;
      instr_q      <= '0;
      data_q       <= '0;
      programmed_q <= '0;
      mesh_run_q   <= 1'b0;
      err_idx_q    <= 1'b0;
    end else begin
      cfg_ready_q  <= cfg_ready_d;
      pe_reset_q   <= pe_reset_d;
      pe_load_q    <= pe_load_d;
      instr_q      <= instr_d;
      data_q       <= data_d;
      programmed_q <= programmed_d;
      mesh_run_q   <= mesh_run_d;
      err_idx_q    <= err_idx_d;
    end
  end

  assign cfg_ready      = cfg_ready_q;
  assign pe_reset       = pe_reset_q;
  assign pe_load        = pe_load_q;
  assign pe_instruction = instr_q;
  assign pe_data        = data_q;
  assign programmed     = programmed_q;
  assign mesh_run       = mesh_run_q;
  assign err_idx        = err_idx_q;

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed bench for pe_config_loader with NUM_PE=16, IDX_W=6, LOAD_GAP=1.
module tb_pe_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [5:0]  cfg_idx;
  logic        cfg_bcast;
  logic        cfg_clear;
  logic [3:0]  cfg_instr;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        reconfig;
  logic [15:0] pe_reset;
  logic [15:0] pe_load;
  logic [3:0]  pe_instruction;
  logic [31:0] pe_data;
  logic [15:0] programmed;
  logic        mesh_run;
  logic        err_idx;

  int n_checks = 0;
  int n_fail   = 0;
  time t_issue;

  pe_config_loader #(.NUM_PE(16), .IDX_W(6), .LOAD_GAP(1)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_bcast(cfg_bcast), .cfg_clear(cfg_clear),
    .cfg_instr(cfg_instr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .reconfig(reconfig), .pe_reset(pe_reset), .pe_load(pe_load),
    .pe_instruction(pe_instruction), .pe_data(pe_data),
    .programmed(programmed), .mesh_run(mesh_run), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cfg_ready, transfers one beat, returns #1 into the ISSUE cycle.
  task automatic send_beat(input logic [5:0] idx, input logic bc, input logic cl,
                           input logic [3:0] ins, input logic [31:0] dat, input logic lst);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: cfg_ready=%b required 1", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_idx = idx; cfg_bcast = bc; cfg_clear = cl;
    cfg_instr = ins; cfg_data = dat; cfg_last = lst;
    @(posedge clk);
    t_issue = $time;
    #1;
    cfg_valid = 1'b0; cfg_bcast = 1'b0; cfg_clear = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++;
    if ({cfg_ready, pe_reset, pe_load, pe_instruction, pe_data, programmed, mesh_run, err_idx}
        !== {1'b0, 16'hFFFF, 16'h0000, 4'h0, 32'h0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b rst=%h load=%h ins=%h data=%h prog=%h run=%b err=%b required 0 ffff 0 0 0 0 0 0",
               cfg_ready, pe_reset, pe_load, pe_instruction, pe_data, programmed, mesh_run, err_idx);
    end
    reset = 1'b0;
    n_checks++;
    if (pe_reset !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_hold: pe_reset=%h required ffff", pe_reset);
    end
    step();
    n_checks++;
    if (pe_reset !== 16'h0000 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: pe_reset=%h ready=%b required 0000 1", pe_reset, cfg_ready);
    end
  endtask

  task automatic test_three_beats();
    time t_prev;
    send_beat(6'd0, 1'b0, 1'b0, 4'b0000, 32'h3F800000, 1'b0);
    t_prev = t_issue;
    n_checks++;
    if (pe_load !== 16'h0001 || pe_instruction !== 4'b0000 || pe_data !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL beat0: load=%h ins=%h data=%h required 0001 0 3f800000", pe_load, pe_instruction, pe_data);
    end
    step();
    n_checks++;
    if (pe_load !== 16'h0000 || cfg_ready !== 1'b0 || pe_data !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL beat0_gap: load=%h ready=%b data=%h required 0000 0 3f800000", pe_load, cfg_ready, pe_data);
    end
    send_beat(6'd5, 1'b0, 1'b0, 4'b0011, 32'h40000000, 1'b0);
    n_checks++;
    if (pe_load !== 16'h0020 || pe_instruction !== 4'b0011 || pe_data !== 32'h40000000) begin
      n_fail++;
      $display("FAIL beat1: load=%h ins=%h data=%h required 0020 3 40000000", pe_load, pe_instruction, pe_data);
    end
    n_checks++;
    if (t_issue - t_prev !== 30) begin
      n_fail++;
      $display("FAIL beat_spacing: %0t required 30", t_issue - t_prev);
    end
    send_beat(6'd15, 1'b0, 1'b0, 4'b1010, 32'h12345678, 1'b1);
    n_checks++;
    if (pe_load !== 16'h8000 || pe_instruction !== 4'b1010 || pe_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL beat2: load=%h ins=%h data=%h required 8000 a 12345678", pe_load, pe_instruction, pe_data);
    end
    step();
    n_checks++;
    if (mesh_run !== 1'b0 || pe_load !== 16'h0000) begin
      n_fail++;
      $display("FAIL beat2_gap: run=%b load=%h required 0 0000", mesh_run, pe_load);
    end
    step();
    n_checks++;
    if (mesh_run !== 1'b1 || programmed !== 16'h8021 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_entry: run=%b prog=%h ready=%b required 1 8021 0", mesh_run, programmed, cfg_ready);
    end
  endtask

  task automatic test_done_hold();
    cfg_valid = 1'b1; cfg_idx = 6'd3; cfg_instr = 4'h1; cfg_data = 32'hDEAD0000;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (cfg_ready !== 1'b0 || mesh_run !== 1'b1 || pe_load !== 16'h0000) begin
        n_fail++;
        $display("FAIL done_hold[%0d]: ready=%b run=%b load=%h required 0 1 0000", i, cfg_ready, mesh_run, pe_load);
      end
    end
    cfg_valid = 1'b0;
    reconfig  = 1'b1;
    step();
    reconfig  = 1'b0;
    n_checks++;
    if (mesh_run !== 1'b0 || programmed !== 16'h0000 || err_idx !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reconfig: run=%b prog=%h err=%b ready=%b required 0 0000 0 1", mesh_run, programmed, err_idx, cfg_ready);
    end
  endtask

  task automatic test_bcast();
    send_beat(6'd63, 1'b1, 1'b0, 4'b0001, 32'hCAFEF00D, 1'b0);
    n_checks++;
    if (pe_load !== 16'hFFFF || programmed !== 16'hFFFF || err_idx !== 1'b0 || pe_reset !== 16'h0000) begin
      n_fail++;
      $display("FAIL bcast: load=%h prog=%h err=%b rst=%h required ffff ffff 0 0000", pe_load, programmed, err_idx, pe_reset);
    end
    step();
    n_checks++;
    if (pe_load !== 16'h0000 || err_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL bcast_after: load=%h err=%b required 0000 0", pe_load, err_idx);
    end
  endtask

  task automatic test_clear();
    send_beat(6'd1, 1'b0, 1'b0, 4'b0010, 32'h0000ABCD, 1'b0);
    n_checks++;
    if (pe_load !== 16'h0002 || pe_instruction !== 4'b0010 || programmed !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL weight_reload: load=%h ins=%h prog=%h required 0002 2 ffff", pe_load, pe_instruction, programmed);
    end
    send_beat(6'd3, 1'b0, 1'b0, 4'b0100, 32'h00000004, 1'b0);
    n_checks++;
    if (pe_load !== 16'h0008) begin
      n_fail++;
      $display("FAIL load3: load=%h required 0008", pe_load);
    end
    send_beat(6'd7, 1'b0, 1'b1, 4'b1111, 32'hFFFFFFFF, 1'b0);
    n_checks++;
    if (pe_reset !== 16'hFFFF || pe_load !== 16'h0000 || programmed !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear: rst=%h load=%h prog=%h required ffff 0000 0000", pe_reset, pe_load, programmed);
    end
    step();
    n_checks++;
    if (pe_reset !== 16'h0000 || programmed !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_after: rst=%h prog=%h required 0000 0000", pe_reset, programmed);
    end
  endtask

  task automatic test_reconfig_ignored();
    send_beat(6'd4, 1'b0, 1'b0, 4'b0101, 32'h55555555, 1'b0);
    step(); step();
    reconfig = 1'b1;
    step();
    reconfig = 1'b0;
    n_checks++;
    if (programmed !== 16'h0010 || mesh_run !== 1'b0) begin
      n_fail++;
      $display("FAIL reconfig_idle: prog=%h run=%b required 0010 0", programmed, mesh_run);
    end
  endtask

  task automatic test_bad_idx();
    send_beat(6'd20, 1'b0, 1'b0, 4'b0110, 32'h66666666, 1'b0);
    n_checks++;
    if (pe_load !== 16'h0000 || pe_reset !== 16'h0000 || err_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_idx: load=%h rst=%h err=%b required 0000 0000 1", pe_load, pe_reset, err_idx);
    end
    send_beat(6'd2, 1'b0, 1'b0, 4'b0111, 32'h77777777, 1'b1);
    n_checks++;
    if (pe_load !== 16'h0004 || err_idx !== 1'b1 || programmed !== 16'h0014) begin
      n_fail++;
      $display("FAIL after_bad: load=%h err=%b prog=%h required 0004 1 0014", pe_load, err_idx, programmed);
    end
    step(); step();
    n_checks++;
    if (mesh_run !== 1'b1 || err_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_done: run=%b err=%b required 1 1", mesh_run, err_idx);
    end
    reconfig = 1'b1;
    step();
    reconfig = 1'b0;
    n_checks++;
    if (mesh_run !== 1'b0 || programmed !== 16'h0000 || err_idx !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reconfig_err: run=%b prog=%h err=%b ready=%b required 0 0000 0 1", mesh_run, programmed, err_idx, cfg_ready);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(6'd7, 1'b0, 1'b0, 4'b1000, 32'h88888888, 1'b0);
    reset = 1'b1;
    step();
    n_checks++;
    if ({cfg_ready, pe_reset, pe_load, pe_instruction, pe_data, programmed, mesh_run, err_idx}
        !== {1'b0, 16'hFFFF, 16'h0000, 4'h0, 32'h0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b rst=%h load=%h ins=%h data=%h prog=%h run=%b err=%b required 0 ffff 0 0 0 0 0 0",
               cfg_ready, pe_reset, pe_load, pe_instruction, pe_data, programmed, mesh_run, err_idx);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (pe_load !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_next: load=%h required 0000", pe_load);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_bcast = 1'b0; cfg_clear = 1'b0;
    cfg_instr = '0; cfg_data = '0; cfg_last = 1'b0; reconfig = 1'b0;
    test_reset();
    test_three_beats();
    test_done_hold();
    test_bcast();
    test_clear();
    test_reconfig_ignored();
    test_bad_idx();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
